// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-serial data-memory controller for the ME request port
//
// Takes a load/store request (addr, wr_data, wr_en, count), runs it as a sequence
// of byte transfers on an external byte bus, and reports the assembled load word
// plus a completion code for one cycle while the pipeline stall drops.
//
// Ports:
//   clk, aresetn        clock (rising edge), asynchronous active-low reset
//   i_req_*             request from EX; count==0 means no request
//   o_stall             hold the pipeline while a request is accepted/in flight
//   o_res_rd_data       load result (zero-extended), valid in the DONE cycle
//   o_res_code          0 NONE, 1 OK, 2 MISALIGNED, 3 BAD_COUNT, 4 TIMEOUT
//   o_bus_*/i_bus_*     byte-wide external bus; i_bus_ready completes a byte
module data_mem_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int WORD_W         = 32,
  parameter int MEM_COUNT_W    = 3,
  parameter int MEM_CODE_W     = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [ADDR_W-1:0]      i_req_addr,
  input  logic [WORD_W-1:0]      i_req_wr_data,
  input  logic                   i_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_req_count,
  output logic                   o_stall,
  output logic [WORD_W-1:0]      o_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_res_code,
  output logic [ADDR_W-1:0]      o_bus_addr,
  output logic [7:0]             o_bus_wr_data,
  output logic                   o_bus_wr_en,
  output logic                   o_bus_rd_en,
  input  logic [7:0]             i_bus_rd_data,
  input  logic                   i_bus_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [MEM_CODE_W-1:0] CODE_NONE    = MEM_CODE_W'(0);
  localparam logic [MEM_CODE_W-1:0] CODE_OK      = MEM_CODE_W'(1);
  localparam logic [MEM_CODE_W-1:0] CODE_MISALIGN = MEM_CODE_W'(2);
  localparam logic [MEM_CODE_W-1:0] CODE_BADCNT  = MEM_CODE_W'(3);
  localparam logic [MEM_CODE_W-1:0] CODE_TIMEOUT = MEM_CODE_W'(4);

  localparam int TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_t                 state, state_d;
  logic [MEM_CODE_W-1:0]  code_q, code_d;
  logic [ADDR_W-1:0]      addr_q;
  logic [WORD_W-1:0]      wdata_q;
  logic [WORD_W-1:0]      rdata_q;
  logic                   wr_en_q;
  logic [MEM_COUNT_W-1:0] count_q;
  logic [1:0]             k_q;
  logic [TW-1:0]          tcnt_q;

  logic       req_valid, cnt_ok, misaligned, last_byte, timeout_hit;
  logic [4:0] bit_lo;

  assign req_valid  = (i_req_count != '0);
  assign cnt_ok     = (i_req_count == MEM_COUNT_W'(1)) || (i_req_count == MEM_COUNT_W'(2)) ||
                      (i_req_count == MEM_COUNT_W'(4));
  assign misaligned = ((i_req_count == MEM_COUNT_W'(2)) && i_req_addr[0]) ||
                      ((i_req_count == MEM_COUNT_W'(4)) && (i_req_addr[1:0] != 2'b00));
  assign last_byte  = (MEM_COUNT_W'(k_q) == (count_q - MEM_COUNT_W'(1)));
  // Fires on the not-ready cycle that brings the wait count up to TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == TW'(TO_LAST));
  assign bit_lo      = {k_q, 3'b000};

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      code_q <= CODE_NONE;
    end else begin
      state  <= state_d;
      code_q <= code_d;
    end
  end

  always_comb begin
    state_d = state;
    code_d  = code_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!cnt_ok) begin
            state_d = DONE;
            code_d  = CODE_BADCNT;
          end else if (misaligned) begin
            state_d = DONE;
            code_d  = CODE_MISALIGN;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (i_bus_ready) begin
          if (last_byte) begin
            state_d = DONE;
            code_d  = CODE_OK;
          end
        end else if (timeout_hit) begin
          state_d = DONE;
          code_d  = CODE_TIMEOUT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_en_q <= 1'b0;
      count_q <= '0;
      k_q     <= '0;
      tcnt_q  <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q  <= i_req_addr;
        wdata_q <= i_req_wr_data;
        wr_en_q <= i_req_wr_en;
        count_q <= i_req_count;
        k_q     <= '0;
        tcnt_q  <= '0;
        rdata_q <= '0;
      end else if (state == ACCESS) begin
        if (i_bus_ready) begin
          tcnt_q <= '0;
          if (!wr_en_q) rdata_q[bit_lo +: 8] <= i_bus_rd_data;
          if (!last_byte) k_q <= k_q + 2'd1;
        end else begin
          tcnt_q <= tcnt_q + TW'(1);
          if (timeout_hit) rdata_q <= '0;
        end
      end
    end
  end

  // Outputs decode from state; the IDLE-cycle stall is gated by reset so every
  // output is 0 while aresetn is low, and strobes drop as soon as state resets.
  always_comb begin
    o_stall       = 1'b0;
    o_res_rd_data = '0;
    o_res_code    = CODE_NONE;
    o_bus_addr    = '0;
    o_bus_wr_data = '0;
    o_bus_wr_en   = 1'b0;
    o_bus_rd_en   = 1'b0;
    case (state)
      IDLE: o_stall = aresetn && req_valid;
      ACCESS: begin
        o_stall       = 1'b1;
        o_bus_addr    = addr_q + ADDR_W'(k_q);
        o_bus_wr_data = wdata_q[bit_lo +: 8];
        o_bus_wr_en   = wr_en_q;
        o_bus_rd_en   = ~wr_en_q;
      end
      DONE: begin
        o_res_code = code_q;
        if (code_q == CODE_OK && !wr_en_q) o_res_rd_data = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory controller directly downstream of the pipeline's ME-side memory request port. It consumes the address, write data, write enable and byte count that EX presents, and executes the access as sequential byte transfers on a byte-wide external bus. It returns the assembled read word and a completion code to ME, and raises a stall while the access is in flight.

Parameters:
ADDR_W, 32, address width
WORD_W, 32, data word width (multiple of 8, at least 32)
MEM_COUNT_W, 3, request byte-count width
MEM_CODE_W, 3, completion-code width
TIMEOUT_CYCLES, 16, consecutive not-ready bus cycles before abort; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
aresetn  in  1  asynchronous active-low reset
i_req_addr  in  ADDR_W  byte address of access
i_req_wr_data  in  WORD_W  store data, little-endian
i_req_wr_en  in  1  1 = store, 0 = load
i_req_count  in  MEM_COUNT_W  bytes to access; 0 = no request
o_stall  out  1  pipeline must hold all stages
o_res_rd_data  out  WORD_W  load result, zero-extended
o_res_code  out  MEM_CODE_W  completion code
o_bus_addr  out  ADDR_W  byte address on external bus
o_bus_wr_data  out  8  byte to write
o_bus_wr_en  out  1  byte write strobe
o_bus_rd_en  out  1  byte read strobe
i_bus_rd_data  in  8  read byte, valid when i_bus_ready=1
i_bus_ready  in  1  bus completes the current byte this cycle

Behaviour:
- Completion codes: 0 NONE, 1 OK, 2 MISALIGNED, 3 BAD_COUNT, 4 TIMEOUT.
- FSM states: IDLE, ACCESS, DONE.
- Reset (aresetn=0, asynchronous): state=IDLE; byte index, timeout counter and latched request all cleared. All outputs are 0 during reset: o_stall, o_res_rd_data, o_res_code (NONE), o_bus_addr, o_bus_wr_data, o_bus_wr_en, o_bus_rd_en.
- Reset asserted mid-access aborts immediately; bus strobes drop without waiting for a clock edge.
- IDLE, i_req_count=0: stay in IDLE; o_stall=0.
- IDLE, i_req_count!=0: o_stall=1 combinationally in the same cycle. At the edge, latch addr, wr_data, wr_en and count, then:
  - count not in {1,2,4}: go to DONE with BAD_COUNT.
  - count=2 with addr[0]!=0, or count=4 with addr[1:0]!=0: go to DONE with MISALIGNED.
  - Otherwise: go to ACCESS with byte index k=0.
  - Error cases generate no bus strobe.
- ACCESS:
  - o_stall=1.
  - o_bus_addr = latched addr + k, modulo 2^ADDR_W.
  - o_bus_wr_en = wr_en; o_bus_rd_en = ~wr_en.
  - o_bus_wr_data = wr_data[8k+7:8k].
  - Strobes are held until i_bus_ready=1.
  - On ready: a load captures i_bus_rd_data into rd_data[8k+7:8k]. If k = count-1, go to DONE with OK; otherwise k increments.
- Timeout: the counter increments on each ACCESS cycle with ready=0 and clears on ready=1. When it reaches TIMEOUT_CYCLES (nonzero), go to DONE with TIMEOUT and discard partial read data.
- DONE, exactly one cycle:
  - o_stall=0, so the pipeline advances at this edge and ME captures the result.
  - o_res_code = latched code.
  - o_res_rd_data = assembled word for an OK load; 0 for stores and errors.
  - Bus strobes are 0.
  - The request visible on the port during DONE is the one just completed and is ignored.
  - Next state is IDLE.
- Outside DONE: o_res_code=NONE and o_res_rd_data=0.
- Latency with ready held at 1: an N-byte access accepted in cycle T produces bus cycles T+1..T+N and DONE at T+N+1, for N+1 stall cycles. Error responses appear at T+1 after 1 stall cycle.
- Upper bytes of o_res_rd_data beyond count are zero. Sign extension is done in ME, not in this block.
- Request inputs may change while o_stall=1; the block uses only the latched copy.

Test Plan:
- Word load: addr 0x100, count 4, wr_en 0, ready=1, bus returns 0x11,0x22,0x33,0x44 -> o_bus_addr 0x100..0x103, o_stall high 5 cycles, DONE shows rd_data 0x44332211, code 1.
- Half store: addr 0x202, count 2, wr_data 0xDEADBEEF, ready=1 -> writes 0xEF@0x202 then 0xBE@0x203, no rd_en, DONE rd_data 0, code 1.
- Misaligned and bad count: word at 0x101 -> code 2 at T+1, no bus strobes; count 3 -> code 3 at T+1.
- Wait states: byte load at 0x7 with ready low for 3 cycles, then high with data 0x80 -> strobe held 4 cycles, rd_data 0x00000080, code 1.
- Timeout: TIMEOUT_CYCLES=4, ready stuck at 0 -> DONE after 4 ACCESS cycles with code 4, rd_data 0; the following request is accepted normally.
- Reset during ACCESS of a word load -> strobes and o_stall drop asynchronously, state returns to IDLE, and the next request completes correctly; also back-to-back requests through DONE->IDLE.
